mem_if_row_loader: RTL and testbench

MEM_IF_ROW_LOADER -- requirements
Module: mem_if_row_loader

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/mem_if_row_loader_if.sv | 49 ++++
 rtl/row_skid_fifo.sv | 53 +++++
 rtl/mem_if_row_loader.sv | 161 ++++++++++++++++
 tb/tb_mem_if_row_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_pkg
// Description : Shared state encoding and default sizing for the row loader.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

    localparam int c_DATA_RATIO = 8;
    localparam int c_ADDR_DEPTH = 32;
    localparam int c_ADDR_WIDTH = 32;
    localparam int c_DATA_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_LOAD = 2'd1;
    localparam state_t c_ST_READ = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

endpackage : mem_if_pkg
`default_nettype wire

// File: rtl/mem_if_row_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_row_loader_if
// Description : Job control, narrow input stream, RAM port and wide output
//               stream of the row loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_if_row_loader_if
    import mem_if_pkg::*;
#(
    parameter int DATA_RATIO = c_DATA_RATIO,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
);
    logic                                   start;
    logic [ADDR_WIDTH-1:0]                  num_words;
    logic                                   busy;
    logic                                   done;

    logic                                   s_valid;
    logic                                   s_ready;
    logic [DATA_WIDTH-1:0]                  s_data;

    logic                                   mem_if_write;
    logic [ADDR_WIDTH-1:0]                  mem_if_address;
    logic [DATA_WIDTH-1:0]                  mem_if_write_data;
    logic [DATA_WIDTH/8-1:0]                mem_if_write_strb;
    logic [DATA_RATIO-1:0][DATA_WIDTH-1:0]  mem_if_read_data;

    logic                                   m_valid;
    logic                                   m_ready;
    logic [DATA_RATIO-1:0][DATA_WIDTH-1:0]  m_data;
    logic                                   m_last;

    // The loader masters both the RAM port and the output stream.
    modport master (
        input  start, num_words, s_valid, s_data, mem_if_read_data, m_ready,
        output busy, done, s_ready, mem_if_write, mem_if_address,
               mem_if_write_data, mem_if_write_strb, m_valid, m_data, m_last
    );

    modport slave (
        output start, num_words, s_valid, s_data, mem_if_read_data, m_ready,
        input  busy, done, s_ready, mem_if_write, mem_if_address,
               mem_if_write_data, mem_if_write_strb, m_valid, m_data, m_last
    );

endinterface : mem_if_row_loader_if
`default_nettype wire

// File: rtl/row_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : row_skid_fifo
// Description : Two-entry FIFO holding returned RAM rows for the output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module row_skid_fifo #(
    parameter int WIDTH = 257
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic [1:0]            o_count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : row_skid_fifo
`default_nettype wire

// File: rtl/mem_if_row_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_row_loader
// Description : Writes a job of narrow words into a wide RAM, then streams the
//               covered rows back out as wide words.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_if_row_loader
    import mem_if_pkg::*;
#(
    parameter int DATA_RATIO = c_DATA_RATIO,
    parameter int ADDR_DEPTH = c_ADDR_DEPTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mem_if_row_loader_if.master  bus
);
    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_ROW_W  = DATA_RATIO * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_MAX_WORDS = ADDR_WIDTH'(ADDR_DEPTH * DATA_RATIO);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_num;
    logic [ADDR_WIDTH-1:0] r_rows;
    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic                  r_pend;
    logic                  r_pend_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_W-1:0]   r_strb;

    logic                  w_accept_start;
    logic [ADDR_WIDTH-1:0] w_num_sat;
    logic [ADDR_WIDTH-1:0] w_rows_sat;
    logic                  w_s_ready;
    logic                  w_wr;
    logic                  w_rd_issue;
    logic                  w_done;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_fifo_valid;
    logic [c_ROW_W:0]      w_fifo_head;
    logic [1:0]            w_fifo_count;

    assign w_accept_start = (r_state == c_ST_IDLE) && bus.start;
    assign w_num_sat      = (bus.num_words > c_MAX_WORDS) ? c_MAX_WORDS : bus.num_words;
    assign w_rows_sat     = (w_num_sat + ADDR_WIDTH'(DATA_RATIO - 1)) / ADDR_WIDTH'(DATA_RATIO);

    assign w_pop = w_fifo_valid && bus.m_ready;
    // Occupancy after this cycle's pop: lets a read go out every cycle while the consumer keeps up.
    assign w_occ = {1'b0, w_fifo_count} + {2'b00, r_pend} - {2'b00, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_wr        = 1'b0;
        w_rd_issue  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (w_num_sat == '0) ? c_ST_DONE : c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_s_ready = 1'b1;
                w_wr      = bus.s_valid;
                if (bus.s_valid && (r_wr_cnt == r_num - ADDR_WIDTH'(1))) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                w_rd_issue = (r_rd_cnt < r_rows) && (w_occ < 3'd2);
                if (w_pop && w_fifo_head[c_ROW_W]) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Idle cycles keep the last address presented to the RAM.
    assign w_addr = w_wr ? r_wr_cnt : (w_rd_issue ? r_rd_cnt : r_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num       <= '0;
            r_rows      <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
        end else begin
            if (w_accept_start) begin
                r_num    <= w_num_sat;
                r_rows   <= w_rows_sat;
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + ADDR_WIDTH'(1);
                r_wdata  <= bus.s_data;
                r_strb   <= '1;
            end
            if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
            end
            r_addr      <= w_addr;
            r_pend      <= w_rd_issue;
            r_pend_last <= w_rd_issue && (r_rd_cnt == r_rows - ADDR_WIDTH'(1));
        end
    end

    row_skid_fifo #(
        .WIDTH   (c_ROW_W + 1)
    ) u_row_skid_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pend),
        .i_data  ({r_pend_last, bus.mem_if_read_data}),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign bus.busy              = (r_state != c_ST_IDLE);
    assign bus.done              = w_done;
    assign bus.s_ready           = w_s_ready;
    assign bus.mem_if_write      = w_wr;
    assign bus.mem_if_address    = w_addr;
    assign bus.mem_if_write_data = w_wr ? bus.s_data : r_wdata;
    assign bus.mem_if_write_strb = w_wr ? {c_STRB_W{1'b1}} : r_strb;
    assign bus.m_valid           = w_fifo_valid;
    assign bus.m_data            = w_fifo_head[c_ROW_W-1:0];
    assign bus.m_last            = w_fifo_valid && w_fifo_head[c_ROW_W];

endmodule : mem_if_row_loader
`default_nettype wire

// File: tb/tb_mem_if_row_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_if_row_loader
// Description : Self-checking bench: job table, reset/abort sequence and
//               randomized jobs against a word-level RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_if_row_loader;
    import mem_if_pkg::*;

    localparam int c_R     = 8;
    localparam int c_DEPTH = 32;
    localparam int c_AW    = 32;
    localparam int c_DW    = 32;
    localparam int c_MAXW  = c_R * c_DEPTH;

    typedef logic [c_R-1:0][c_DW-1:0] row_t;
    typedef struct {
        int nw; int vpct; int rpct; int stall; int poke;
        int exp_wr; int exp_rows; int exp_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;
    always #5 clk = ~clk;

    mem_if_row_loader_if #(.DATA_RATIO(c_R), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus ();

    mem_if_row_loader #(
        .DATA_RATIO (c_R),
        .ADDR_DEPTH (c_DEPTH),
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks;
    int errors;
    int w_idx;
    int row_idx;
    int job_rows;
    row_t ram [c_DEPTH];
    row_t gold [c_DEPTH];
    row_t gold_save [c_DEPTH];
    logic [c_DW-1:0] exp_words [$];
    row_t exp_rows [$];

    function automatic row_t pattern(input int r);
        row_t x;
        for (int k = 0; k < c_R; k++) x[k] = 32'hA500_0000 | 32'(r << 8) | 32'(k);
        return x;
    endfunction

    // Wide synchronous RAM: narrow-word writes, row read data one cycle later.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int j = 0; j < c_DEPTH; j++) ram[j] <= pattern(j);
        end else if (bus.mem_if_write) begin
            ram[bus.mem_if_address[7:3]][bus.mem_if_address[2:0]] <= bus.mem_if_write_data;
        end
        bus.mem_if_read_data <= ram[bus.mem_if_address[4:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input row_t act, input row_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   32'(bus.busy), 0);
        chk({tag, "_done"},   32'(bus.done), 0);
        chk({tag, "_sready"}, 32'(bus.s_ready), 0);
        chk({tag, "_write"},  32'(bus.mem_if_write), 0);
        chk({tag, "_mvalid"}, 32'(bus.m_valid), 0);
        chk({tag, "_mlast"},  32'(bus.m_last), 0);
        chk({tag, "_addr"},   bus.mem_if_address, 0);
        chk({tag, "_wdata"},  bus.mem_if_write_data, 0);
        chk({tag, "_strb"},   32'(bus.mem_if_write_strb), 0);
        chk_row({tag, "_mdata"}, bus.m_data, '0);
    endtask

    // Expected stream for a job: words land at narrow index i, rows are read back whole.
    task automatic prepare(input int nw, output int sat, output int rows);
        sat  = (nw > c_MAXW) ? c_MAXW : nw;
        rows = (sat + c_R - 1) / c_R;
        exp_words.delete();
        exp_rows.delete();
        for (int i = 0; i < sat; i++) begin
            exp_words.push_back($urandom);
            gold[i / c_R][i % c_R] = exp_words[i];
        end
        for (int r = 0; r < rows; r++) exp_rows.push_back(gold[r]);
        w_idx    = 0;
        row_idx  = 0;
        job_rows = rows;
    endtask

    task automatic monitor();
        logic hold_pend = 1'b0;
        row_t hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 32'(bus.m_valid), 1);
                    chk_row("hold_data", bus.m_data, hold_data);
                end
                hold_pend = bus.m_valid && !bus.m_ready;
                hold_data = bus.m_data;
                if (bus.mem_if_write) begin
                    chk("wr_in_range", 32'(w_idx < exp_words.size()), 1);
                    chk("wr_addr", bus.mem_if_address, 32'(w_idx));
                    chk("wr_strb", 32'(bus.mem_if_write_strb), 32'hF);
                    if (w_idx < exp_words.size()) chk("wr_data", bus.mem_if_write_data, exp_words[w_idx]);
                    w_idx++;
                end
                if (bus.m_valid) begin
                    chk("m_last", 32'(bus.m_last), 32'(row_idx == job_rows - 1));
                end else begin
                    chk("m_last_idle", 32'(bus.m_last), 0);
                end
                if (bus.m_valid && bus.m_ready) begin
                    chk("row_in_range", 32'(row_idx < exp_rows.size()), 1);
                    if (row_idx < exp_rows.size()) chk_row("m_data", bus.m_data, exp_rows[row_idx]);
                    row_idx++;
                end
            end
        end
    endtask

    task automatic run_job(input vec_t v);
        int sat, rows, sent, cyc, done_cyc, stall_cnt;
        bit poked;
        prepare(v.nw, sat, rows);
        sent = 0; cyc = 0; done_cyc = -1; stall_cnt = 0; poked = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_words = 32'(v.nw); bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (v.poke != 0 && !poked && sent == 4) begin
                bus.start = 1'b1; bus.num_words = 32'd3; poked = 1;
            end
            bus.s_valid = ($urandom_range(1, 100) <= v.vpct);
            bus.s_data  = (sent < sat) ? exp_words[sent] : $urandom;
            if (v.stall > 0) begin
                bus.m_ready = (sent == sat) && (stall_cnt >= v.stall);
                if (sent == sat) stall_cnt++;
            end else begin
                bus.m_ready = ($urandom_range(1, 100) <= v.rpct);
            end
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) sent++;
            if (bus.done) begin
                done_cyc = cyc;
                chk("busy_at_done", 32'(bus.busy), 1);
            end
        end
        chk("done_seen", 32'(done_cyc >= 0), 1);
        if (v.exp_cyc > 0) chk("done_cycle", done_cyc, v.exp_cyc);
        chk("writes", w_idx, v.exp_wr);
        chk("rows", row_idx, v.exp_rows);
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        vec_t tbl [10];
        vec_t v;
        int sat, rows, sent, cyc;
        checks = 0; errors = 0;
        rst = 1'b1; ram_init = 1'b1;
        bus.start = 1'b0; bus.num_words = '0; bus.s_valid = 1'b1; bus.s_data = '0; bus.m_ready = 1'b1;
        for (int j = 0; j < c_DEPTH; j++) gold[j] = pattern(j);
        w_idx = 0; row_idx = 0; job_rows = 0;

        //          nw  vpct rpct stall poke wr rows cyc
        tbl[0] = '{16,  100, 100, 0,    0,   16, 2,  21};
        tbl[1] = '{12,  100, 100, 0,    0,   12, 2,  17};
        tbl[2] = '{0,   100, 100, 0,    0,   0,  0,  1};
        tbl[3] = '{1,   100, 100, 0,    0,   1,  1,  5};
        tbl[4] = '{8,   100, 100, 0,    0,   8,  1,  12};
        tbl[5] = '{9,   100, 100, 0,    0,   9,  2,  14};
        tbl[6] = '{300, 100, 100, 0,    0,   256, 32, 291};
        tbl[7] = '{16,  100, 100, 5,    0,   16, 2,  24};
        tbl[8] = '{12,  100, 100, 0,    1,   12, 2,  17};
        tbl[9] = '{20,  50,  60,  0,    0,   20, 3,  0};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        bus.s_valid = 1'b0; bus.m_ready = 1'b0;

        for (int t = 0; t < 10; t++) run_job(tbl[t]);

        // Abort a job after five writes; the next job must restart at address 0.
        gold_save = gold;
        prepare(16, sat, rows);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_words = 32'd16;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.s_valid = 1'b1;
        sent = 0; cyc = 0;
        while (sent < 5 && cyc < 50) begin
            bus.s_data = exp_words[sent];
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_sent", sent, 5);
        rst = 1'b1;
        #1;
        check_zero("abort");
        chk("abort_writes", w_idx, 5);
        @(posedge clk); #1;
        rst = 1'b0; bus.s_valid = 1'b0;
        gold = gold_save;
        for (int i = 0; i < 5; i++) gold[0][i] = exp_words[i];
        run_job('{8, 100, 100, 0, 0, 8, 1, 12});

        for (int n = 0; n < 25; n++) begin
            v.nw    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 400)) : int'($urandom_range(0, 40));
            v.vpct  = $urandom_range(30, 100);
            v.rpct  = $urandom_range(30, 100);
            v.stall = 0;
            v.poke  = 0;
            sat        = (v.nw > c_MAXW) ? c_MAXW : v.nw;
            v.exp_wr   = sat;
            v.exp_rows = (sat + c_R - 1) / c_R;
            v.exp_cyc  = 0;
            run_job(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_if_row_loader
`default_nettype wire
